alu_operand_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the shared ALU datapath of the RV32I core. It accepts one decoded instruction at a time and walks it through DECODE/EXEC/MEM/WB. On every cycle it drives the ALU B-operand select (0 = ru_rs2, 1 = Imm_ext), the A-operand select and the datapath write strobes. It sits between the instruction-fetch stage and the operand muxes, register unit and data-memory port.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_operand_sequencer_opcode_class_decode.sv | 32 +++
 rtl/alu_operand_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ALU operand sequencer.
// The TRAP state exists only when ALU_SEQ_TRAP_EN is defined.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
`ifdef ALU_SEQ_TRAP_EN
        , ST_TRAP
`endif
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CLS_ADD   = 2'b00;
    localparam logic [1:0] CLS_FUNCT = 2'b01;
    localparam logic [1:0] CLS_CMP   = 2'b10;
    localparam logic [1:0] CLS_PASSB = 2'b11;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_UNKNOWN
    } op_class_t;

endpackage

// File: rtl/alu_operand_sequencer_opcode_class_decode.sv
// Combinational opcode classifier: instruction class plus ALU operand
// selects and operation class for the shared datapath.
module opcode_class_decode
    import alu_seq_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       a_src,
    output logic       b_src,
    output logic [1:0] op_cls
);

    always_comb begin
        op_class = C_UNKNOWN;
        a_src    = 1'b0;
        b_src    = 1'b0;
        op_cls   = CLS_ADD;
        case (opcode)
            OP_R:      begin op_class = C_R;                    op_cls = CLS_FUNCT; end
            OP_I:      begin op_class = C_I;      b_src = 1'b1; op_cls = CLS_FUNCT; end
            OP_LOAD:   begin op_class = C_LOAD;   b_src = 1'b1; end
            OP_STORE:  begin op_class = C_STORE;  b_src = 1'b1; end
            OP_BRANCH: begin op_class = C_BRANCH;               op_cls = CLS_CMP;   end
            OP_JAL:    begin op_class = C_JAL;    a_src = 1'b1; b_src = 1'b1; end
            OP_AUIPC:  begin op_class = C_AUIPC;  a_src = 1'b1; b_src = 1'b1; end
            OP_JALR:   begin op_class = C_JALR;   b_src = 1'b1; end
            OP_LUI:    begin op_class = C_LUI;    b_src = 1'b1; op_cls = CLS_PASSB; end
            default:   op_class = C_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle IDLE/DECODE/EXEC/MEM/WB sequencer for the shared RV32I ALU.
// Define ALU_SEQ_TRAP_EN to trap unknown opcodes instead of treating them as NOPs.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       alu_a_src,
    output logic       alu_b_src,
    output logic [1:0] alu_op_cls,
    output logic       ru_wr,
    output logic       dm_rd,
    output logic       dm_wr,
    output logic       pc_wr,
    output logic       mem_err,
    output logic       illegal
);

    localparam logic [7:0] TIMEOUT_CNT = MEM_TIMEOUT[7:0];

    state_t     state_reg;
    logic [6:0] opcode_reg;
    logic [7:0] cnt_reg;
    logic       mem_err_reg;

    op_class_t  dec_class;
    logic       dec_a;
    logic       dec_b;
    logic [1:0] dec_cls;

    opcode_class_decode u_decode (
        .opcode   (opcode_reg),
        .op_class (dec_class),
        .a_src    (dec_a),
        .b_src    (dec_b),
        .op_cls   (dec_cls)
    );

    logic timeout;
    logic mem_done;
    assign timeout  = (cnt_reg + 8'd1) == TIMEOUT_CNT;
    assign mem_done = mem_ready || timeout;

`ifdef ALU_SEQ_TRAP_EN
    logic illegal_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            opcode_reg  <= '0;
            cnt_reg     <= '0;
            mem_err_reg <= 1'b0;
`ifdef ALU_SEQ_TRAP_EN
            illegal_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: if (instr_valid) begin
                    opcode_reg <= opcode;
                    state_reg  <= ST_DECODE;
`ifdef ALU_SEQ_TRAP_EN
                    illegal_reg <= 1'b0;
`endif
                end
                ST_DECODE: if (dec_class == C_UNKNOWN) begin
`ifdef ALU_SEQ_TRAP_EN
                    state_reg   <= ST_TRAP;
                    illegal_reg <= 1'b1;
`else
                    state_reg   <= ST_IDLE;
`endif
                end else begin
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    cnt_reg <= '0;
                    if (dec_class == C_LOAD || dec_class == C_STORE)
                        state_reg <= ST_MEM;
                    else if (dec_class == C_BRANCH)
                        state_reg <= ST_IDLE;
                    else
                        state_reg <= ST_WB;
                end
                ST_MEM: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (mem_done) begin
                        // A response arriving on the last allowed cycle still counts as on time.
                        if (!mem_ready)
                            mem_err_reg <= 1'b1;
                        state_reg <= (dec_class == C_LOAD) ? ST_WB : ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    logic in_op;
    assign in_op = (state_reg == ST_EXEC) || (state_reg == ST_MEM) || (state_reg == ST_WB);

    assign instr_ready = (state_reg == ST_IDLE);
    assign alu_a_src   = in_op && dec_a;
    assign alu_b_src   = in_op && dec_b;
    assign alu_op_cls  = in_op ? dec_cls : CLS_ADD;
    assign ru_wr       = (state_reg == ST_WB);
    assign dm_rd       = (state_reg == ST_MEM) && (dec_class == C_LOAD);
    assign dm_wr       = (state_reg == ST_MEM) && (dec_class == C_STORE);
    assign mem_err     = mem_err_reg;

    // The STORE retire pulse marks the MEM exit cycle, so it follows mem_ready in that cycle.
    logic pc_final;
    assign pc_final = (state_reg == ST_WB)
                   || ((state_reg == ST_EXEC) && (dec_class == C_BRANCH))
                   || (dm_wr && mem_done);

`ifdef ALU_SEQ_TRAP_EN
    assign pc_wr   = pc_final || (state_reg == ST_TRAP);
    assign illegal = illegal_reg;
`else
    assign pc_wr   = pc_final || ((state_reg == ST_DECODE) && (dec_class == C_UNKNOWN));
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: directed table, async-reset sequence, then random
// instructions compared cycle by cycle against a phase-level model.
module tb_alu_operand_sequencer;

    localparam int TO = 15;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_UNK = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       alu_a_src;
    logic       alu_b_src;
    logic [1:0] alu_op_cls;
    logic       ru_wr;
    logic       dm_rd;
    logic       dm_wr;
    logic       pc_wr;
    logic       mem_err;
    logic       illegal;

    alu_operand_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .alu_a_src   (alu_a_src),
        .alu_b_src   (alu_b_src),
        .alu_op_cls  (alu_op_cls),
        .ru_wr       (ru_wr),
        .dm_rd       (dm_rd),
        .dm_wr       (dm_wr),
        .pc_wr       (pc_wr),
        .mem_err     (mem_err),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit err_s    = 1'b0;
    bit ill_s    = 1'b0;
    bit noise    = 1'b0;

    typedef struct {
        logic [6:0] op;
        int         k;
        logic       a;
        logic       b;
        logic [1:0] cls;
    } vec_t;

    vec_t tbl[11];

    // Spec-level classification of an opcode.
    task automatic get_info(input logic [6:0] op, output int kind,
                            output logic a, output logic b, output logic [1:0] cls);
        kind = K_ALU; a = 0; b = 0; cls = 2'b00;
        case (op)
            7'b0110011: begin cls = 2'b01; end
            7'b0010011: begin b = 1; cls = 2'b01; end
            7'b0000011: begin kind = K_LOAD; b = 1; end
            7'b0100011: begin kind = K_STORE; b = 1; end
            7'b1100011: begin kind = K_BRANCH; cls = 2'b10; end
            7'b1101111: begin a = 1; b = 1; end
            7'b0010111: begin a = 1; b = 1; end
            7'b1100111: begin b = 1; end
            7'b0110111: begin b = 1; cls = 2'b11; end
            default:    kind = K_UNK;
        endcase
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {instr_ready, alu_a_src, alu_b_src, alu_op_cls, ru_wr, dm_rd, dm_wr, pc_wr, mem_err, illegal};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs rdy,a,b,cls,ru,rd,wr,pc,err,ill got %b required %b", name, act, exp);
        end
    endtask

    // o = {ready, a, b, cls[1:0], ru_wr, dm_rd, dm_wr, pc_wr}
    task automatic cyc(input string name, input logic [8:0] o);
        @(negedge clk);
        check(name, {o, err_s, ill_s});
        @(posedge clk);
        #1;
    endtask

    task automatic set_noise();
        instr_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        opcode      = 7'($urandom);
        mem_ready   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] op, input int k,
                             input logic ea, input logic eb, input logic [1:0] ecls);
        int kind;
        int n;
        bit to;
        logic ma, mb;
        logic [1:0] mc;
        get_info(op, kind, ma, mb, mc);
        $display("instr opcode=%b mem_ready_at=%0d kind=%0d", op, k, kind);
        instr_valid = 1'b1;
        opcode      = op;
        mem_ready   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc("accept", {1'b1, 8'b0});
        ill_s = 1'b0;
        set_noise();
        if (kind == K_UNK) begin
`ifdef ALU_SEQ_TRAP_EN
            cyc("decode_unknown", 9'b0);
            ill_s = 1'b1;
            set_noise();
            cyc("trap", 9'b0_0_0_00_0001);
`else
            cyc("decode_nop", 9'b0_0_0_00_0001);
`endif
            return;
        end
        cyc("decode", 9'b0);
        set_noise();
        cyc("exec", {1'b0, ea, eb, ecls, 3'b000, 1'(kind == K_BRANCH)});
        if (kind == K_BRANCH) return;
        if (kind == K_LOAD || kind == K_STORE) begin
            to = !(k >= 1 && k <= TO);
            n  = to ? TO : k;
            for (int i = 1; i <= n; i++) begin
                set_noise();
                mem_ready = (i == k);
                cyc("mem", {1'b0, ea, eb, ecls, 1'b0, 1'(kind == K_LOAD),
                            1'(kind == K_STORE), 1'(kind == K_STORE && i == n)});
            end
            if (to) err_s = 1'b1;
            if (kind == K_STORE) return;
        end
        set_noise();
        cyc("wb", {1'b0, ea, eb, ecls, 4'b1001});
    endtask

    initial begin
        tbl[0]  = '{7'b0110011, 0, 1'b0, 1'b0, 2'b01};
        tbl[1]  = '{7'b0010011, 0, 1'b0, 1'b1, 2'b01};
        tbl[2]  = '{7'b0000011, 3, 1'b0, 1'b1, 2'b00};
        tbl[3]  = '{7'b0100011, 0, 1'b0, 1'b1, 2'b00};
        tbl[4]  = '{7'b1100011, 0, 1'b0, 1'b0, 2'b10};
        tbl[5]  = '{7'b1101111, 0, 1'b1, 1'b1, 2'b00};
        tbl[6]  = '{7'b0010111, 0, 1'b1, 1'b1, 2'b00};
        tbl[7]  = '{7'b1100111, 0, 1'b0, 1'b1, 2'b00};
        tbl[8]  = '{7'b0110111, 0, 1'b0, 1'b1, 2'b11};
        tbl[9]  = '{7'b1111111, 0, 1'b0, 1'b0, 2'b00};
        tbl[10] = '{7'b0100011, 2, 1'b0, 1'b1, 2'b00};

        rst_n = 1'b1; instr_valid = 1'b0; opcode = '0; mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset_state", 11'b1_0_0_00_0000_0_0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 11; t++)
            run_instr(tbl[t].op, tbl[t].k, tbl[t].a, tbl[t].b, tbl[t].cls);
        cyc("idle_after_table", {1'b1, 8'b0});

        // Asynchronous reset in the middle of a LOAD's MEM phase.
        $display("instr opcode=0000011 reset during MEM");
        instr_valid = 1'b1; opcode = 7'b0000011; mem_ready = 1'b0;
        cyc("rst_accept", {1'b1, 8'b0});
        ill_s = 1'b0;
        instr_valid = 1'b0;
        cyc("rst_decode", 9'b0);
        cyc("rst_exec", 9'b0_0_1_00_0000);
        cyc("rst_mem1", 9'b0_0_1_00_0100);
        #2 rst_n = 1'b0;
        err_s = 1'b0; ill_s = 1'b0;
        #1 check("reset_async_drop", 11'b1_0_0_00_0000_0_0);
        @(negedge clk);
        check("reset_held", 11'b1_0_0_00_0000_0_0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        cyc("post_reset_idle1", {1'b1, 8'b0});
        cyc("post_reset_idle2", {1'b1, 8'b0});

        // Random instruction stream with input noise outside the windows that matter.
        noise = 1'b1;
        for (int r = 0; r < 60; r++) begin
            logic [6:0] op;
            int kind;
            logic a, b;
            logic [1:0] cls;
            case ($urandom_range(0, 9))
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                4: op = 7'b1100011;
                5: op = 7'b1101111;
                6: op = 7'b0010111;
                7: op = 7'b1100111;
                8: op = 7'b0110111;
                default: op = 7'($urandom);
            endcase
            get_info(op, kind, a, b, cls);
            run_instr(op, $urandom_range(0, 18), a, b, cls);
        end
        noise = 1'b0;
        set_noise();
        cyc("final_idle", {1'b1, 8'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
